// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
// The arbiter takes the slave view. The requesters and the memory together take
// the master view.
interface data_mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // Port 0: processor data port
  logic          r0_req;
  logic          r0_we;
  logic          r0_lock;
  logic [AW-1:0] r0_addr;
  logic [DW-1:0] r0_wdata;
  logic          r0_gnt;
  logic          r0_rvalid;
  logic [DW-1:0] r0_rdata;

  // Port 1: secondary master (loader / debug DMA)
  logic          r1_req;
  logic          r1_we;
  logic          r1_lock;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r1_wdata;
  logic          r1_gnt;
  logic          r1_rvalid;
  logic [DW-1:0] r1_rdata;

  // Single-ported synchronous-read memory side
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  r0_req, r0_we, r0_lock, r0_addr, r0_wdata,
    output r0_gnt, r0_rvalid, r0_rdata,
    input  r1_req, r1_we, r1_lock, r1_addr, r1_wdata,
    output r1_gnt, r1_rvalid, r1_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output r0_req, r0_we, r0_lock, r0_addr, r0_wdata,
    input  r0_gnt, r0_rvalid, r0_rdata,
    output r1_req, r1_we, r1_lock, r1_addr, r1_wdata,
    input  r1_gnt, r1_rvalid, r1_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of a single-ported, synchronous-read data memory.
// Arbitration is round-robin per access. A port can hold a bounded locked
// ownership for back-to-back sequences.
// Grants are combinational, so an eligible request is accepted at the same edge.
// Read data comes back one cycle after a read grant.
module data_mem_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_LOCK = 8
) (
  input  logic              clk,
  input  logic              reset,
  data_mem_arbiter_if.slave bus
);

  localparam int LCW = (MAX_LOCK > 2) ? $clog2(MAX_LOCK) : 1;
  localparam logic [LCW-1:0] LOCK_LAST = LCW'(MAX_LOCK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t         state_reg, state_next;
  logic           last_reg, last_next;
  logic [LCW-1:0] lock_cnt_reg, lock_cnt_next;
  logic [1:0]     rd_pend_reg, rd_pend_next;

  // Requester views indexed by port number
  logic [1:0]     req;
  logic [1:0]     we;
  logic [1:0]     lock;
  logic [AW-1:0]  addr  [2];
  logic [DW-1:0]  wdata [2];
  logic [DW-1:0]  rdata [2];

  logic [1:0]     gnt;
  logic           owner;
  logic           owner_active;
  logic           sel;

  assign req      = {bus.r1_req,  bus.r0_req};
  assign we       = {bus.r1_we,   bus.r0_we};
  assign lock     = {bus.r1_lock, bus.r0_lock};
  assign addr[0]  = bus.r0_addr;
  assign addr[1]  = bus.r1_addr;
  assign wdata[0] = bus.r0_wdata;
  assign wdata[1] = bus.r1_wdata;

  // Arbitration: the owner keeps the port while it requests, otherwise round-robin
  always_comb begin
    gnt           = 2'b00;
    sel           = 1'b0;
    state_next    = state_reg;
    last_next     = last_reg;
    lock_cnt_next = lock_cnt_reg;
    owner         = (state_reg == OWN1);
    owner_active  = ((state_reg == OWN0) && req[0]) ||
                    ((state_reg == OWN1) && req[1]);

    if (!reset) begin
      // Nothing is granted while reset is held, even with requests pending
      gnt = 2'b00;
    end else if (owner_active) begin
      gnt       = owner ? 2'b10 : 2'b01;
      last_next = owner;
      // Release on an unlocked access or after the last allowed locked grant
      if (!lock[owner] || (lock_cnt_reg == LOCK_LAST)) begin
        state_next    = IDLE;
        lock_cnt_next = '0;
      end else begin
        lock_cnt_next = lock_cnt_reg + 1'b1;
      end
    end else begin
      // Idle arbitration, also used when an owner stops requesting
      sel = (req[0] && req[1]) ? ~last_reg : req[1];
      if (req != 2'b00) begin
        gnt       = sel ? 2'b10 : 2'b01;
        last_next = sel;
        if (lock[sel]) begin
          state_next    = sel ? OWN1 : OWN0;
          lock_cnt_next = LCW'(1);
        end else begin
          state_next    = IDLE;
          lock_cnt_next = '0;
        end
      end else begin
        state_next    = IDLE;
        lock_cnt_next = '0;
      end
    end
  end

  // Arbitration state with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      last_reg     <= 1'b1;
      lock_cnt_reg <= '0;
      rd_pend_reg  <= 2'b00;
    end else begin
      state_reg    <= state_next;
      last_reg     <= last_next;
      lock_cnt_reg <= lock_cnt_next;
      rd_pend_reg  <= rd_pend_next;
    end
  end

  // Memory request mux: the granted port drives the macro, zeros when idle
  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (gnt[0]) begin
      bus.mem_we    = we[0];
      bus.mem_addr  = addr[0];
      bus.mem_wdata = wdata[0];
    end else if (gnt[1]) begin
      bus.mem_we    = we[1];
      bus.mem_addr  = addr[1];
      bus.mem_wdata = wdata[1];
    end
  end

  assign bus.mem_en = |gnt;

  // Per-port read return: a read grant raises rvalid for exactly the next cycle
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ret
      assign rd_pend_next[gi] = gnt[gi] & ~we[gi];
      assign rdata[gi]        = rd_pend_reg[gi] ? bus.mem_rdata : '0;
    end
  endgenerate

  assign bus.r0_gnt    = gnt[0];
  assign bus.r1_gnt    = gnt[1];
  assign bus.r0_rvalid = rd_pend_reg[0];
  assign bus.r1_rvalid = rd_pend_reg[1];
  assign bus.r0_rdata  = rdata[0];
  assign bus.r1_rdata  = rdata[1];

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Shares one single-ported, synchronous-read data memory between two requesters: port 0 is the processor data port (`address_to_mem`/`data_to_mem`/`WE`) and port 1 is a secondary master such as the loader/debug DMA. It arbitrates round-robin per access and supports bounded locked ownership for back-to-back sequences. It returns read data with one-cycle latency. It sits between the processor top level and the data memory macro; the processor is stalled externally while its `r0_gnt` is low.

## Interface
- `AW`, 32, address width in bits
- `DW`, 32, data width in bits
- `MAX_LOCK`, 8, maximum consecutive granted cycles one port may hold under lock (≥2)

- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted)
- `r0_req`, `r1_req`  in  1  access request; held with stable address, write enable and write data until the matching `gnt` is seen high
- `r0_we`, `r1_we`  in  1  1 = write, 0 = read
- `r0_lock`, `r1_lock`  in  1  request to keep ownership after this grant
- `r0_addr`, `r1_addr`  in  AW  word address
- `r0_wdata`, `r1_wdata`  in  DW  write data
- `r0_gnt`, `r1_gnt`  out  1  combinational; access is accepted at this clock edge
- `r0_rvalid`, `r1_rvalid`  out  1  registered; read data valid, one cycle after a read grant
- `r0_rdata`, `r1_rdata`  out  DW  equals `mem_rdata` while the matching `rvalid` is high, 0 otherwise
- `mem_en`  out  1  memory access strobe, equal to OR of the grants
- `mem_we`, `mem_addr`, `mem_wdata`  out  1/AW/DW  muxed from the granted port; 0 when idle
- `mem_rdata`  in  DW  memory read data, valid one cycle after a read with `mem_en` high

## Operation
- States: IDLE, OWN0, OWN1. Registers: `last` (last port granted), `lock_cnt` (width clog2(MAX_LOCK)), `rd_pend[1:0]`.
- **IDLE**
  - One requester: grant it.
  - Both requesting: grant `!last`.
  - On grant: `last` <= granted port.
  - If the granted port's lock is high: go to OWNn with `lock_cnt`=1.
- **OWNn**
  - If `rn_req` is high: grant n only; the other port is blocked.
    - `lock_cnt`++.
    - If `rn_lock` is low, or `lock_cnt`==MAX_LOCK-1: go to IDLE and clear `lock_cnt`.
  - If `rn_req` is low: behave as IDLE this cycle, including granting the other port and applying lock entry, and leave OWNn.
- **Forced release:** after MAX_LOCK consecutive locked grants, the next cycle is IDLE with `last`=n. If both ports are requesting, the other port wins.
- **Read return:** `rd_pend[n]` <= `gnt_n` & `!rn_we`; `rn_rvalid` = `rd_pend[n]`. Writes produce no response.
- Exactly one grant per cycle at most. `r0_gnt` & `r1_gnt` is never 1.

## Timing
- **Reset** (`reset`=0, asynchronous):
  - state IDLE, `last`=1 (port 0 wins first contention), `lock_cnt`=0, `rd_pend`=0.
  - All `gnt`/`rvalid`/`rdata`/`mem_*` outputs are 0.
- **Grant:** same cycle as the request when the port is eligible, i.e. zero latency. The memory samples at that edge.
- **Read:** data on `rn_rdata` with `rn_rvalid` in the following cycle. Sustained throughput is 1 access/cycle.
- **Pipelined reads:** a grant to port 1 in the cycle port 0's rvalid is high is legal. The return buses are independent.
- **Reset mid-operation:**
  - Pending read responses are dropped; `rvalid` stays low after reset release.
  - Lock ownership is discarded.
- **Request withdrawal:** a request deasserted before grant is not serviced and has no side effects.
- **Boundary addresses:** addr 0 and addr 2^AW-1 pass through unmodified; no wrap or alignment logic.

## Test plan
- **Reset:** assert `reset`=0 mid-read (port 0 granted read to 0x10) -> next cycle `r0_rvalid`=0; all outputs 0; after release, first contention grants port 0.
- **Contention:** both ports request reads every cycle (r0 addr 0x4, r1 addr 0x8; mem returns addr+0x100) for 4 cycles -> grants alternate 0,1,0,1; `r0_rdata`=0x104 and `r1_rdata`=0x108 each one cycle after their grant.
- **Lock:** port 1 locked writes to 0x20..0x3C while port 0 requests continuously -> port 1 granted 8 consecutive cycles, then port 0 granted, then port 1 resumes.
- **Early unlock:** port 0 lock for 3 grants, then `r0_lock`=0 on the 3rd -> state IDLE after 3 grants; port 1 granted next cycle.
- **Owner idle:** in OWN0, `r0_req` drops while `r1_req`=1 -> port 1 granted in that same cycle; state leaves OWN0.
- **Write then read:** port 0 writes 0xDEADBEEF to 0x40, then reads 0x40 -> `mem_we`=1 on first grant, no `rvalid`; second access returns 0xDEADBEEF with `r0_rvalid`=1.
